// File: rtl/worker_pkg.sv
// -----------------------------------------------------------------------------
// worker_pkg
//   Shared constants for the worker / NEXT-PROPOSAL reader slice and the
//   state encoding of the reader FSM.
//   DEF_* values are the default build of the partitioning worker; modules
//   take them as parameter defaults so a different build only overrides
//   parameters at instantiation.
// -----------------------------------------------------------------------------
package worker_pkg;

    localparam int DEF_K               = 16;  // partitions
    localparam int DEF_Q               = 16;  // lanes per buffer word
    localparam int DEF_NEXT_BW         = 4;   // bits per next-partition entry
    localparam int DEF_NEXT_ADDR_SPACE = 4;   // buffer address width
    localparam int DEF_PRO_BW          = 8;   // bits per proposal entry
    localparam int DEF_VID_BW          = 16;  // global vertex id width
    localparam int DEF_BATCH_BW        = 8;   // batch number width
    localparam int DEF_CNT_BW          = 16;  // per-partition counter width

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LD   = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } rd_state_t;

endpackage

// File: rtl/next_pro_reader_part_counter_bank.sv
// -----------------------------------------------------------------------------
// part_counter_bank
//   K saturating counters, one per partition. A single increment per cycle
//   selects its counter by idx; an idx outside 0..K-1 matches no counter and
//   is dropped. clr zeroes every counter and takes priority over inc.
// Ports
//   clk    in   1          clock
//   rst_n  in   1          synchronous active-low reset (counters to 0)
//   clr    in   1          synchronous clear of all counters
//   inc    in   1          increment the counter selected by idx
//   idx    in   IDX_W      counter index
//   cnt    out  K*CNT_BW   counter p = bits [p*CNT_BW +: CNT_BW]
// -----------------------------------------------------------------------------
module part_counter_bank #(
    parameter int K      = worker_pkg::DEF_K,
    parameter int IDX_W  = worker_pkg::DEF_NEXT_BW,
    parameter int CNT_BW = worker_pkg::DEF_CNT_BW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    input  logic [IDX_W-1:0]      idx,
    output logic [K*CNT_BW-1:0]   cnt
);

    logic [CNT_BW-1:0] cnt_r [K];

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_BW-1:0] sat_inc(input logic [CNT_BW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int p = 0; p < K; p++) begin
                cnt_r[p] <= '0;
            end
        end else if (inc) begin
            for (int p = 0; p < K; p++) begin
                if (idx == IDX_W'(p)) begin
                    cnt_r[p] <= sat_inc(cnt_r[p]);
                end
            end
        end
    end

    for (genvar p = 0; p < K; p++) begin : g_flat
        assign cnt[p*CNT_BW +: CNT_BW] = cnt_r[p];
    end

endmodule

// File: rtl/next_pro_reader.sv
// -----------------------------------------------------------------------------
// next_pro_reader
//   Read-side consumer of the NEXT / PROPOSAL buffers. On an accepted
//   batch_finish it sweeps every buffer word, serialises each lane as
//   (vid, next partition, proposal) on a valid/ready stream, and counts
//   accepted entries per destination partition.
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   en                    start enable (batch_finish accepted only when 1)
//   batch_finish          1-cycle pulse: buffers hold a complete batch
//   batch_num             batch id, sampled with batch_finish
//   next_raddr/pro_raddr  buffer read address (identical), 1-cycle latency
//   next_rdata/pro_rdata  buffer words, lane i at [i*BW +: BW]
//   out_valid/out_ready   stream handshake
//   out_vid/part/pro      stream payload
//   busy                  sweep in progress (RD..DONE)
//   done                  1-cycle pulse after the last handshake
//   part_cnt              saturating per-partition accepted-entry counts
//   cnt_clr               synchronous clear of part_cnt
//   err_overrun           sticky: batch_finish seen while busy
// -----------------------------------------------------------------------------
module next_pro_reader #(
    parameter int K               = worker_pkg::DEF_K,
    parameter int Q               = worker_pkg::DEF_Q,
    parameter int NEXT_BW         = worker_pkg::DEF_NEXT_BW,
    parameter int NEXT_ADDR_SPACE = worker_pkg::DEF_NEXT_ADDR_SPACE,
    parameter int PRO_BW          = worker_pkg::DEF_PRO_BW,
    parameter int VID_BW          = worker_pkg::DEF_VID_BW,
    parameter int BATCH_BW        = worker_pkg::DEF_BATCH_BW,
    parameter int CNT_BW          = worker_pkg::DEF_CNT_BW
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        batch_finish,
    input  logic [BATCH_BW-1:0]         batch_num,
    output logic [NEXT_ADDR_SPACE-1:0]  next_raddr,
    input  logic [Q*NEXT_BW-1:0]        next_rdata,
    output logic [NEXT_ADDR_SPACE-1:0]  pro_raddr,
    input  logic [Q*PRO_BW-1:0]         pro_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [VID_BW-1:0]           out_vid,
    output logic [NEXT_BW-1:0]          out_part,
    output logic [PRO_BW-1:0]           out_pro,
    output logic                        busy,
    output logic                        done,
    output logic [K*CNT_BW-1:0]         part_cnt,
    input  logic                        cnt_clr,
    output logic                        err_overrun
);

    import worker_pkg::*;

    localparam int A      = NEXT_ADDR_SPACE;
    localparam int LANE_W = (Q > 1) ? $clog2(Q) : 1;
    localparam int unsigned WORD_STRIDE = Q * (2 ** A);   // vids per batch
    localparam logic [A-1:0]      ADDR_LAST = '1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(Q - 1);

    rd_state_t             state, state_nxt;
    logic [A-1:0]          addr_r;
    logic [A-1:0]          raddr_r;
    logic [LANE_W-1:0]     lane_r;
    logic [BATCH_BW-1:0]   batch_r;
    logic                  err_r;
    logic [Q*NEXT_BW-1:0]  next_word_p1;
    logic [Q*PRO_BW-1:0]   pro_word_p1;

    logic start;
    logic hs;
    logic last_lane;
    logic [NEXT_BW-1:0] lane_part;
    logic [PRO_BW-1:0]  lane_pro;
    logic [VID_BW-1:0]  lane_vid;

    assign start     = batch_finish & en & (state == ST_IDLE);
    assign hs        = out_valid & out_ready;
    assign last_lane = (lane_r == LANE_LAST);

    // ---- FSM state register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM next state and decoded outputs ----
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_RD;
                end
            end
            ST_RD: state_nxt = ST_LD;
            ST_LD: state_nxt = ST_EMIT;
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready && last_lane) begin
                    state_nxt = (addr_r == ADDR_LAST) ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---- Sweep control: batch latch, word address, lane index, error flag ----
    // raddr is a register loaded only when the next word is requested, so it
    // sits on the RD-cycle value for the whole LD/EMIT span.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r  <= '0;
            raddr_r <= '0;
            lane_r  <= '0;
            batch_r <= '0;
            err_r   <= 1'b0;
        end else begin
            if (batch_finish && state != ST_IDLE) begin
                err_r <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        batch_r <= batch_num;
                        addr_r  <= '0;
                        raddr_r <= '0;
                    end
                end
                ST_LD: lane_r <= '0;
                ST_EMIT: begin
                    if (hs) begin
                        lane_r <= lane_r + 1'b1;
                        if (last_lane && addr_r != ADDR_LAST) begin
                            addr_r  <= addr_r + 1'b1;
                            raddr_r <= addr_r + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- Stage p1: buffer words captured one cycle after the read ----
    always_ff @(posedge clk) begin
        if (state == ST_LD) begin
            next_word_p1 <= next_rdata;
            pro_word_p1  <= pro_rdata;
        end
    end

    // Lane mux; payload is forced to 0 outside EMIT so the word registers
    // need no reset to keep outputs clean after reset.
    assign lane_part = next_word_p1[lane_r*NEXT_BW +: NEXT_BW];
    assign lane_pro  = pro_word_p1[lane_r*PRO_BW +: PRO_BW];
    assign lane_vid  = VID_BW'(batch_r) * VID_BW'(WORD_STRIDE)
                     + VID_BW'(addr_r) * VID_BW'(Q)
                     + VID_BW'(lane_r);

    assign out_part    = out_valid ? lane_part : '0;
    assign out_pro     = out_valid ? lane_pro  : '0;
    assign out_vid     = out_valid ? lane_vid  : '0;
    assign next_raddr  = raddr_r;
    assign pro_raddr   = raddr_r;
    assign err_overrun = err_r;

    part_counter_bank #(
        .K      (K),
        .IDX_W  (NEXT_BW),
        .CNT_BW (CNT_BW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (hs),
        .idx   (out_part),
        .cnt   (part_cnt)
    );

endmodule
